// File: rtl/fill_mix_pkg.sv
// rtl/fill_mix_pkg.sv - shared state type, timing defaults and width helper for the fill/mix scheduler
package fill_mix_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_FILL  = 3'd2,
    S_FLUSH = 3'd3,
    S_MIX   = 3'd4,
    S_DONE  = 3'd5
  } sched_state_e;

  localparam int DEF_N_CH         = 8;
  localparam int DEF_N_STG        = 4;
  localparam int DEF_FILL_CYCLES  = 16;
  localparam int DEF_MIX_CYCLES   = 32;
  localparam int DEF_FLUSH_CYCLES = 4;

  // bits needed to hold a down-counter loaded with n
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fill_mix_scheduler_if.sv
// rtl/fill_mix_scheduler_if.sv - host/driver signal bundle of the fill/mix scheduler
interface fill_mix_scheduler_if
  import fill_mix_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int N_STG = DEF_N_STG
);
  logic              start;
  logic              abort;
  logic [N_CH-1:0]   fill_req;
  logic [N_CH-1:0]   valve_open;
  logic              flush_open;
  logic [N_STG-1:0]  mix_en;
  logic              fill_done;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, fill_req,
    input  valve_open, flush_open, mix_en, fill_done, busy, done
  );

  modport slave (
    input  start, abort, fill_req,
    output valve_open, flush_open, mix_en, fill_done, busy, done
  );
endinterface

// File: rtl/fill_mix_scheduler_rr_pick.sv
// rtl/fill_mix_scheduler_rr_pick.sv - combinational round-robin first-set search starting at ptr
module rr_pick #(
  parameter int N_CH = 8
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] ptr,
  output logic                    valid,
  output logic [$clog2(N_CH)-1:0] index
);
  localparam int IW = $clog2(N_CH);

  // walk ptr, ptr+1, ... wrapping at N_CH and keep the first requester seen
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = 0; i < N_CH; i++) begin
      int j;
      logic [IW-1:0] jj;
      j = int'(ptr) + i;
      if (j >= N_CH) j = j - N_CH;
      jj = IW'(j);
      if (!valid && req[jj]) begin
        valid = 1'b1;
        index = jj;
      end
    end
  end
endmodule

// File: rtl/fill_mix_scheduler.sv
// rtl/fill_mix_scheduler.sv - shared-inlet fill arbiter and mixer sequencer; SCHED_FLUSH_EN adds an inlet flush after each fill
module fill_mix_scheduler
  import fill_mix_pkg::*;
#(
  parameter int N_CH         = DEF_N_CH,
  parameter int N_STG        = DEF_N_STG,
  parameter int FILL_CYCLES  = DEF_FILL_CYCLES,
  parameter int MIX_CYCLES   = DEF_MIX_CYCLES,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fill_mix_scheduler_if.slave  bus
);
  localparam int IW    = $clog2(N_CH);
  localparam int SW    = (N_STG > 1) ? $clog2(N_STG) : 1;
  // one width fits every phase counter, sized by the longest phase
  localparam int CNT_W = cnt_w(max3(FILL_CYCLES, MIX_CYCLES, FLUSH_CYCLES));

  sched_state_e      state, state_nxt;
  logic [N_CH-1:0]   pending;
  logic [IW-1:0]     rr_ptr, g, pick_idx;
  logic              pick_valid;
  logic [SW-1:0]     stg;
  logic [CNT_W-1:0]  fill_cnt, mix_cnt;
  logic              fill_last, mix_last, stg_last, abort_hit;

  logic [N_CH-1:0]   valve_open_c;
  logic [N_STG-1:0]  mix_en_c;
  logic              flush_open_c, fill_done_c, busy_c, done_c;

`ifdef SCHED_FLUSH_EN
  logic [CNT_W-1:0]  flush_cnt;
  logic              flush_last;
  assign flush_last = (flush_cnt == CNT_W'(1));
`endif

  assign fill_last = (fill_cnt == CNT_W'(1));
  assign mix_last  = (mix_cnt == CNT_W'(1));
  assign stg_last  = (stg == SW'(N_STG - 1));
  assign abort_hit = bus.abort && (state != S_IDLE);

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req   (pending),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state: abort beats every other transition
  always_comb begin
    state_nxt = state;
    if (abort_hit) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.start) state_nxt = S_ARB;
        S_ARB:  state_nxt = pick_valid ? S_FILL : S_MIX;
        S_FILL: begin
          if (fill_last) begin
`ifdef SCHED_FLUSH_EN
            state_nxt = S_FLUSH;
`else
            state_nxt = S_ARB;
`endif
          end
        end
`ifdef SCHED_FLUSH_EN
        S_FLUSH: if (flush_last) state_nxt = S_ARB;
`endif
        S_MIX:  if (mix_last && stg_last) state_nxt = S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // pending set, round-robin pointer, grant, stage index and phase counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      rr_ptr   <= '0;
      g        <= '0;
      stg      <= '0;
      fill_cnt <= '0;
      mix_cnt  <= '0;
`ifdef SCHED_FLUSH_EN
      flush_cnt <= '0;
`endif
    end else if (abort_hit) begin
      pending  <= '0;
      stg      <= '0;
      fill_cnt <= '0;
      mix_cnt  <= '0;
`ifdef SCHED_FLUSH_EN
      flush_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (bus.start) pending <= bus.fill_req;
        S_ARB: begin
          if (pick_valid) begin
            g        <= pick_idx;
            fill_cnt <= CNT_W'(FILL_CYCLES);
          end else begin
            stg     <= '0;
            mix_cnt <= CNT_W'(MIX_CYCLES);
          end
        end
        S_FILL: begin
          if (fill_last) begin
            fill_cnt   <= '0;
            pending[g] <= 1'b0;
            rr_ptr     <= (g == IW'(N_CH - 1)) ? '0 : g + 1'b1;
`ifdef SCHED_FLUSH_EN
            flush_cnt  <= CNT_W'(FLUSH_CYCLES);
`endif
          end else begin
            fill_cnt <= fill_cnt - 1'b1;
          end
        end
`ifdef SCHED_FLUSH_EN
        S_FLUSH: flush_cnt <= flush_last ? '0 : flush_cnt - 1'b1;
`endif
        S_MIX: begin
          if (mix_last) begin
            if (stg_last) begin
              mix_cnt <= '0;
            end else begin
              stg     <= stg + 1'b1;
              mix_cnt <= CNT_W'(MIX_CYCLES);
            end
          end else begin
            mix_cnt <= mix_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // outputs decode purely from state so reset clears them at once
  always_comb begin
    valve_open_c = '0;
    mix_en_c     = '0;
    flush_open_c = 1'b0;
    fill_done_c  = 1'b0;
    busy_c       = (state != S_IDLE);
    done_c       = (state == S_DONE);
    if (state == S_FILL) begin
      valve_open_c = N_CH'(1) << g;
      fill_done_c  = fill_last;
    end
    if (state == S_MIX) mix_en_c = N_STG'(1) << stg;
`ifdef SCHED_FLUSH_EN
    flush_open_c = (state == S_FLUSH);
`endif
  end

  assign bus.valve_open = valve_open_c;
  assign bus.mix_en     = mix_en_c;
  assign bus.flush_open = flush_open_c;
  assign bus.fill_done  = fill_done_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;

endmodule

// File: tb/tb_fill_mix_scheduler.sv
// tb/tb_fill_mix_scheduler.sv - scoreboard bench for fill_mix_scheduler (honours SCHED_FLUSH_EN)
module tb_fill_mix_scheduler;
  localparam int K_FILL  = 1;
  localparam int K_FLUSH = 2;
  localparam int K_MIX   = 3;
  localparam int K_DONE  = 4;

  typedef struct {
    int         kind;
    logic [7:0] val;
    int         len;
    int         fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   start_cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  fill_mix_scheduler_if #(.N_CH(8), .N_STG(4)) bus ();

  fill_mix_scheduler #(
    .N_CH(8), .N_STG(4), .FILL_CYCLES(16), .MIX_CYCLES(32), .FLUSH_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(input int kind, input logic [7:0] val, input int len, input int fd);
    exp_t e;
    e.kind = kind; e.val = val; e.len = len; e.fd = fd;
    exp_q.push_back(e);
  endfunction

  // a complete fill: one valve for 16 cycles with fill_done on its last cycle
  function automatic void push_fill(input int ch);
    logic [7:0] v;
    v = 8'h01 << ch;
    push(K_FILL, v, 16, 3);
`ifdef SCHED_FLUSH_EN
    push(K_FLUSH, 8'h01, 4, 0);
`endif
  endfunction

  function automatic void push_mix();
    push(K_MIX, 8'h01, 32, 0);
    push(K_MIX, 8'h02, 32, 0);
    push(K_MIX, 8'h04, 32, 0);
    push(K_MIX, 8'h08, 32, 0);
  endfunction

  function automatic void end_seg(input int kind, input logic [7:0] val, input int len, input int fd);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("seg_unexpected", kind * 256 + int'(val), 0);
    end else begin
      e = exp_q.pop_front();
      chk("seg_kind_val", kind * 256 + int'(val), e.kind * 256 + int'(e.val));
      chk("seg_len", len, e.len);
      chk("seg_fill_done", fd, e.fd);
    end
  endfunction

  // monitor: rebuild valve/flush/mix segments and done pulses, compare against the queue
  logic [7:0] v_prev = '0;
  logic [3:0] m_prev = '0;
  logic       f_prev = 1'b0;
  int         v_len = 0, v_fdcnt = 0, v_fdlast = 0, m_len = 0, f_len = 0;

  always @(negedge clk) begin
    exp_t e;
    chk("valve_onehot0", $onehot0(bus.valve_open), 1);
    chk("mix_onehot0", $onehot0(bus.mix_en), 1);
    chk("flush_valve_excl", bus.flush_open && (bus.valve_open != 0), 0);
    chk("fill_done_needs_valve", bus.fill_done && (bus.valve_open == 0), 0);
`ifndef SCHED_FLUSH_EN
    chk("flush_tied_low", bus.flush_open, 0);
`endif
    if (v_prev != 0 && bus.valve_open != v_prev)
      end_seg(K_FILL, v_prev, v_len, v_fdcnt * 2 + v_fdlast);
    if (bus.valve_open != 0 && bus.valve_open != v_prev) begin
      chk("valve_gap", v_prev, 0);
      v_len = 1; v_fdcnt = int'(bus.fill_done); v_fdlast = int'(bus.fill_done);
    end else if (bus.valve_open != 0) begin
      v_len++; v_fdcnt += int'(bus.fill_done); v_fdlast = int'(bus.fill_done);
    end
    v_prev = bus.valve_open;

    if (f_prev && !bus.flush_open) end_seg(K_FLUSH, 8'h01, f_len, 0);
    if (bus.flush_open) f_len = f_prev ? f_len + 1 : 1;
    f_prev = bus.flush_open;

    if (m_prev != 0 && bus.mix_en != m_prev) end_seg(K_MIX, {4'b0, m_prev}, m_len, 0);
    if (bus.mix_en != 0 && bus.mix_en != m_prev) m_len = 1;
    else if (bus.mix_en != 0) m_len++;
    m_prev = bus.mix_en;

    if (bus.done) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("done_kind", K_DONE, e.kind);
        chk("done_latency", cyc - start_cyc + 1, e.len);
      end
    end
  end

  task automatic run(input logic [7:0] req);
    @(negedge clk);
    bus.fill_req = req;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", bus.done, 1);
    @(negedge clk);
    chk("busy_after_done", bus.busy, 0);
  endtask

  task automatic wait_valve(input logic [7:0] v, input int budget);
    int n;
    n = 0;
    while (bus.valve_open !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("saw_valve", bus.valve_open, v);
  endtask

  task automatic wait_mix(input logic [3:0] m, input int budget);
    int n;
    n = 0;
    while (bus.mix_en !== m && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("saw_mix", bus.mix_en, m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.fill_req = '0;
    #2;
    chk("reset_outputs", {bus.valve_open, bus.mix_en, bus.flush_open, bus.fill_done, bus.busy, bus.done}, 0);
    #10 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: four chambers from rr_ptr=0
    push_fill(0); push_fill(2); push_fill(5); push_fill(7); push_mix();
`ifdef SCHED_FLUSH_EN
    push(K_DONE, 8'h00, 1 + 4 * 21 + 128 + 1, 0);
`else
    push(K_DONE, 8'h00, 198, 0);
`endif
    run(8'hA5);
    wait_done(1000);

    // 2: all chambers, search restarts after chamber 7 so order is 0..7
    for (int i = 0; i < 8; i++) push_fill(i);
    push_mix();
`ifdef SCHED_FLUSH_EN
    push(K_DONE, 8'h00, 1 + 8 * 21 + 128 + 1, 0);
`else
    push(K_DONE, 8'h00, 266, 0);
`endif
    run(8'hFF);
    wait_done(1000);

    // 3: empty request runs mixers only
    push_mix();
    push(K_DONE, 8'h00, 130, 0);
    run(8'h00);
    wait_done(1000);

    // 4: abort four cycles into the fill of chamber 2, then refill it
    push(K_FILL, 8'h04, 4, 0);
    run(8'h0C);
    wait_valve(8'h04, 100);
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("abort_outputs", {bus.valve_open, bus.mix_en, bus.flush_open, bus.fill_done, bus.busy, bus.done}, 0);
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", bus.busy, 0);
    push_fill(2); push_mix();
`ifdef SCHED_FLUSH_EN
    push(K_DONE, 8'h00, 1 + 21 + 128 + 1, 0);
`else
    push(K_DONE, 8'h00, 147, 0);
`endif
    run(8'h04);
    wait_done(1000);

    // 5: async reset in the second mix stage; start ignored while held
    push(K_MIX, 8'h01, 32, 0);
    push(K_MIX, 8'h02, 3, 0);
    run(8'h00);
    wait_mix(4'b0010, 200);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", {bus.valve_open, bus.mix_en, bus.flush_open, bus.fill_done, bus.busy, bus.done}, 0);
    bus.fill_req = 8'hFF;
    bus.start    = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    bus.start = 1'b0;
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("start_ignored_in_rst", bus.busy, 0);
    // rr_ptr back at 0 after reset, so chamber 1 precedes chamber 4
    push_fill(1); push_fill(4); push_mix();
`ifdef SCHED_FLUSH_EN
    push(K_DONE, 8'h00, 1 + 2 * 21 + 128 + 1, 0);
`else
    push(K_DONE, 8'h00, 164, 0);
`endif
    run(8'h12);
    wait_done(1000);

    // 6: two chambers, wrapping from rr_ptr=5 to 0 then 1
    push_fill(0); push_fill(1); push_mix();
`ifdef SCHED_FLUSH_EN
    push(K_DONE, 8'h00, 172, 0);
`else
    push(K_DONE, 8'h00, 164, 0);
`endif
    run(8'h03);
    wait_done(1000);

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
